// File: rtl/fifo_wr_packer_if.sv
// Interface bundling the packer's request inputs and its FIFO write-side outputs.
// The master modport is the packer; the slave modport is whatever drives and observes it.
interface fifo_wr_packer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_WIDTH      = 16,
  parameter int DROP_CNT_WIDTH = 4
);
  logic [ALU_WIDTH-1:0]      alu_out;
  logic                      alu_valid;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;
  logic                      wfull;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      winc;
  logic                      busy;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  modport master (
    input  alu_out, alu_valid, rd_data, rd_valid, wfull,
    output wdata, winc, busy, drop_cnt
  );

  modport slave (
    output alu_out, alu_valid, rd_data, rd_valid, wfull,
    input  wdata, winc, busy, drop_cnt
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Serialises a 16-bit ALU result or an 8-bit register read into FIFO bytes, LSB first.
// Requests seen while a transfer is pending are dropped and counted (saturating).
module fifo_wr_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_WIDTH      = 16,
  parameter int DROP_CNT_WIDTH = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_packer_if.master   bus
);
  localparam int NBYTES = ALU_WIDTH / DATA_WIDTH;
  localparam int IDX_W  = $clog2(NBYTES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [ALU_WIDTH-1:0]      r_shift;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          r_cnt;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  logic                      w_winc;
  logic                      w_last;
  logic                      w_accept_alu;
  logic                      w_accept_rd;
  logic [1:0]                w_drop_inc;
  logic [DROP_CNT_WIDTH:0]   w_drop_sum;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_winc       = 1'b0;
    w_accept_alu = 1'b0;
    w_accept_rd  = 1'b0;
    w_drop_inc   = 2'd0;
    w_last       = (r_idx == r_cnt - IDX_W'(1));
    case (r_state)
      IDLE: begin
        if (bus.alu_valid) begin
          w_accept_alu = 1'b1;
          w_next_state = SEND;
          if (bus.rd_valid) w_drop_inc = 2'd1;
        end else if (bus.rd_valid) begin
          w_accept_rd  = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        w_winc     = !bus.wfull;
        // No back-to-back acceptance: the final SEND cycle still drops strobes.
        w_drop_inc = {1'b0, bus.alu_valid} + {1'b0, bus.rd_valid};
        if (w_winc && w_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_WIDTH+1)'(w_drop_inc);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_shift    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept_alu) begin
        r_shift <= bus.alu_out;
        r_cnt   <= IDX_W'(NBYTES);
        r_idx   <= '0;
      end else if (w_accept_rd) begin
        r_shift <= ALU_WIDTH'(bus.rd_data);
        r_cnt   <= IDX_W'(1);
        r_idx   <= '0;
      end else if (w_winc && !w_last) begin
        r_shift <= r_shift >> DATA_WIDTH;
        r_idx   <= r_idx + IDX_W'(1);
      end

      if (w_drop_sum[DROP_CNT_WIDTH]) r_drop_cnt <= '1;
      else                            r_drop_cnt <= w_drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  // winc is purely a function of state and wfull, so a reset drops it without waiting for a clock.
  assign bus.wdata    = r_shift[DATA_WIDTH-1:0];
  assign bus.winc     = w_winc;
  assign bus.busy     = (r_state == SEND);
  assign bus.drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Randomised scoreboard bench for fifo_wr_packer: a byte-level reference model fills an
// expected-byte queue and a negedge monitor checks every write and the status outputs.
module tb_fifo_wr_packer;
  localparam int DW       = 8;
  localparam int AW       = 16;
  localparam int CW       = 4;
  localparam int NB       = AW / DW;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;

  fifo_wr_packer_if #(.DATA_WIDTH(DW), .ALU_WIDTH(AW), .DROP_CNT_WIDTH(CW)) bus ();

  fifo_wr_packer #(.DATA_WIDTH(DW), .ALU_WIDTH(AW), .DROP_CNT_WIDTH(CW)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: bytes still owed for the current request, plus the expected byte stream.
  logic [DW-1:0] exp_q[$];
  int            pending = 0;
  int            drops   = 0;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      pending = 0;
      drops   = 0;
      exp_q.delete();
    end else begin
      if (pending > 0) begin
        drops += int'(bus.alu_valid) + int'(bus.rd_valid);
        if (!bus.wfull) pending--;
      end else if (bus.alu_valid) begin
        for (int i = 0; i < NB; i++) exp_q.push_back(DW'(bus.alu_out >> (DW * i)));
        pending = NB;
        if (bus.rd_valid) drops++;
      end else if (bus.rd_valid) begin
        exp_q.push_back(bus.rd_data);
        pending = 1;
      end
      if (drops > DROP_MAX) drops = DROP_MAX;
    end
  end

  // Monitor: mid-cycle, compare status against the model and each written byte against the queue.
  always @(negedge wclk) begin
    if (wrst_n) begin
      check("busy", 32'(bus.busy), 32'(pending > 0));
      check("winc", 32'(bus.winc), 32'((pending > 0) && !bus.wfull));
      check("drop_cnt", 32'(bus.drop_cnt), 32'(drops));
      if (bus.winc) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(bus.wdata), 32'hFFFF_FFFF);
        end else begin
          check("wdata", 32'(bus.wdata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  task automatic strobe(input logic a_v, input logic [AW-1:0] a_d,
                        input logic r_v, input logic [DW-1:0] r_d);
    bus.alu_valid = a_v;
    bus.alu_out   = a_d;
    bus.rd_valid  = r_v;
    bus.rd_data   = r_d;
    next_cycle();
    bus.alu_valid = 1'b0;
    bus.rd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!bus.busy) break;
      next_cycle();
    end
    check({name, "_idle_timeout"}, 32'(bus.busy), 32'd0);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_out   = '0;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = '0;
    bus.wfull     = 1'b0;

    // Reset values
    #12;
    check("rst_winc", 32'(bus.winc), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_wdata", 32'(bus.wdata), 32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    wrst_n = 1'b1;
    next_cycle();

    // ALU result, no stall: 0x34 then 0x12
    strobe(1'b1, 16'h1234, 1'b0, 8'h00);
    wait_idle("alu_1234");
    check("alu_1234_drop", 32'(bus.drop_cnt), 32'd0);

    // Single register byte
    strobe(1'b0, 16'h0000, 1'b1, 8'h7E);
    wait_idle("rd_7e");

    // Stall of 3 cycles starting at the first SEND cycle
    strobe(1'b1, 16'hBEEF, 1'b0, 8'h00);
    bus.wfull = 1'b1;
    repeat (3) next_cycle();
    bus.wfull = 1'b0;
    wait_idle("alu_beef_stall");

    // Width rule
    strobe(1'b1, 16'hA5C3, 1'b0, 8'h00);
    wait_idle("alu_a5c3");

    // Simultaneous strobes: ALU wins, rd dropped
    strobe(1'b1, 16'h0102, 1'b1, 8'h55);
    wait_idle("both");
    check("both_drop_cnt", 32'(bus.drop_cnt), 32'd1);

    // Long stall with rd strobed every cycle: counter saturates
    strobe(1'b1, 16'hCAFE, 1'b0, 8'h00);
    bus.wfull = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = 8'(i);
      next_cycle();
    end
    bus.rd_valid = 1'b0;
    check("sat_drop_cnt", 32'(bus.drop_cnt), 32'(DROP_MAX));
    bus.wfull = 1'b0;
    wait_idle("sat");
    check("sat_hold", 32'(bus.drop_cnt), 32'(DROP_MAX));

    // Reset during the second byte of an ALU transfer
    strobe(1'b1, 16'hD00D, 1'b0, 8'h00);
    next_cycle();
    wrst_n = 1'b0;
    #1;
    check("midrst_winc", 32'(bus.winc), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    next_cycle();
    next_cycle();
    #2;
    wrst_n = 1'b1;
    next_cycle();
    strobe(1'b0, 16'h0000, 1'b1, 8'h99);
    wait_idle("post_rst_rd");

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      bus.alu_valid = ($urandom_range(0, 4) == 0);
      bus.rd_valid  = ($urandom_range(0, 4) == 0);
      bus.alu_out   = AW'($urandom);
      bus.rd_data   = DW'($urandom);
      bus.wfull     = ($urandom_range(0, 3) == 0);
      next_cycle();
    end
    bus.alu_valid = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.wfull     = 1'b0;
    wait_idle("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
- Write-domain producer that sits directly upstream of the async FIFO write side.
- Accepts a 16-bit ALU result or an 8-bit register-file read word, serialises it into bytes, and drives the FIFO write port (wdata/winc), obeying wfull.
- Bytes go out LSB first, so the downstream UART TX path always sees ALU results as low byte, then high byte.
- Requests arriving while a transfer is in progress are dropped and counted.

Parameters:
- DATA_WIDTH, 8, FIFO word width; must match the FIFO wdata width.
- ALU_WIDTH, 16, ALU result width; must be an integer multiple of DATA_WIDTH. NBYTES = ALU_WIDTH/DATA_WIDTH.
- DROP_CNT_WIDTH, 4, width of the saturating dropped-request counter.

Ports:
- wclk  in  1  write-domain clock; all state updates on the rising edge.
- wrst_n  in  1  asynchronous active-low reset.
- alu_out  in  ALU_WIDTH  ALU result.
- alu_valid  in  1  one-cycle strobe; alu_out is valid in this cycle.
- rd_data  in  DATA_WIDTH  register-file read data.
- rd_valid  in  1  one-cycle strobe; rd_data is valid in this cycle.
- wfull  in  1  FIFO full flag from the write side.
- wdata  out  DATA_WIDTH  byte presented to the FIFO.
- winc  out  1  FIFO write request.
- busy  out  1  high while a transfer is pending.
- drop_cnt  out  DROP_CNT_WIDTH  saturating count of dropped requests.

Behaviour:
- Reset (wrst_n low, async): state=IDLE; shift register=0; byte index=0; byte count=0; drop_cnt=0. Outputs during reset: wdata=0, winc=0, busy=0.
- States:
  - IDLE: busy=0, winc=0.
  - SEND: busy=1.
- Transitions from IDLE:
  - alu_valid=1 at an edge: latch alu_out into the shift register, byte count=NBYTES, index=0, go to SEND.
  - Otherwise rd_valid=1: latch rd_data zero-extended, byte count=1, index=0, go to SEND.
  - Both strobes in the same cycle: ALU wins; the rd request is dropped and drop_cnt increments.
- SEND behaviour:
  - wdata = shift_reg[DATA_WIDTH-1:0] (registered source, stable through the state).
  - winc = !wfull (combinational from state and wfull). No write is ever issued while wfull=1.
  - At an edge with winc=1:
    - If index==count-1: go to IDLE; the shift register is left as is.
    - Else: shift right by DATA_WIDTH and increment index.
  - At an edge with wfull=1: hold everything. The stall may last any number of cycles.
- Latency: a strobe at edge N gives the first winc in cycle N+1 when the FIFO is not full. An ALU result with no stall occupies exactly 2 winc cycles (N+1, N+2). busy returns low in cycle N+3.
- Drop rule: any alu_valid or rd_valid sampled while busy=1 is ignored. This includes the final SEND cycle, so no back-to-back acceptance. Each dropped strobe increments drop_cnt by 1; both strobes dropped in one cycle increment it by 2. drop_cnt saturates at all-ones. It is cleared only by reset.
- wdata in IDLE holds the last shifted value and is don't-care to the FIFO. A bench must not check it when winc=0.
- Reset mid-transfer: the transfer is aborted immediately, winc drops asynchronously, and partial bytes are lost.
- Width rule: with DATA_WIDTH=8 and ALU_WIDTH=16, 0xA5C3 is emitted as 0xC3 then 0xA5.

Test Plan:
- Reset, then alu_out=0x1234 with alu_valid for 1 cycle, wfull=0 -> winc high 2 cycles with wdata 0x34 then 0x12; busy high 2 cycles; drop_cnt=0.
- rd_data=0x7E strobe with wfull=0 -> single winc cycle with wdata=0x7E; busy low the following cycle.
- alu_out=0xBEEF strobe, wfull forced high for 3 cycles starting with the first SEND cycle -> winc=0 for those 3 cycles, then 0xEF, 0xBE written; no byte duplicated or skipped.
- alu_valid and rd_valid together (0x0102, 0x55) -> only 0x02, 0x01 written; drop_cnt=1.
- Strobe rd_valid in every cycle during a long wfull stall (20 cycles) -> drop_cnt saturates at 15 and does not wrap.
- Assert wrst_n low during the second byte of an ALU transfer -> winc=0 and busy=0 immediately, drop_cnt=0; a next rd strobe of 0x99 after release is written normally.
